// File: rtl/mem_vec_store_seq.sv
// Memory-stage sequencer: serialises a masked 4-lane vector store onto one 32-bit port and stalls upstream.
// Optional store-beat counter output store_cnt enabled by defining VEC_STORE_CNT_EN.
module mem_vec_store_seq #(
    parameter int unsigned ADDR_W = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite_in,
    input  logic              memWrite_in,
    input  logic              updateCnt_in,
    input  logic              select_in,
    input  logic [3:0]        rd_in,
    input  logic [3:0]        resCompare_in,
    input  logic [31:0]       aluRes0_in,
    input  logic [31:0]       aluRes1_in,
    input  logic [31:0]       aluRes2_in,
    input  logic [31:0]       aluRes3_in,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              stop,
    output logic              regWrite_out,
    output logic [3:0]        rd_out,
    output logic [31:0]       aluRes0_out,
    output logic [31:0]       aluRes1_out,
    output logic [31:0]       aluRes2_out,
    output logic [31:0]       aluRes3_out,
`ifdef VEC_STORE_CNT_EN
    output logic [15:0]       store_cnt,
`endif
    output logic [ADDR_W-1:0] ptr_out
);

    localparam int unsigned LANES = 4;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                       state, stateNext;
    logic [ADDR_W-1:0]            ptr;
    logic [ADDR_W-1:0]            base;
    logic [LANES-1:0]             mask, maskNext;
    logic [LANES-1:0][31:0]       laneData;
    logic [LANES-1:0]             acceptMask;
    logic                         storeGo;
    logic [1:0]                   laneIdx;

    assign ptr_out = ptr;

    // Next state, lane selection and memory-port drive (memory port depends on state only, plus reset abort)
    always_comb begin
        stateNext  = state;
        maskNext   = mask;
        acceptMask = select_in ? resCompare_in : 4'b1111;
        storeGo    = memWrite_in && (acceptMask != 4'b0000);
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        if (mask[0])      laneIdx = 2'd0;
        else if (mask[1]) laneIdx = 2'd1;
        else if (mask[2]) laneIdx = 2'd2;
        else              laneIdx = 2'd3;

        case (state)
            IDLE: begin
                if (storeGo) stateNext = BURST;
            end
            BURST: begin
                mem_we    = !reset;
                mem_addr  = base + ADDR_W'(laneIdx);
                mem_wdata = laneData[laneIdx];
                if (mem_ready) begin
                    maskNext = mask & ~(4'b0001 << laneIdx);
                    if (maskNext == 4'b0000) stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= BASE_ADDR;
            base         <= '0;
            mask         <= '0;
            laneData     <= '0;
            stop         <= 1'b0;
            regWrite_out <= 1'b0;
            rd_out       <= '0;
            aluRes0_out  <= '0;
            aluRes1_out  <= '0;
            aluRes2_out  <= '0;
            aluRes3_out  <= '0;
        end else begin
            state <= stateNext;
            stop  <= (stateNext == BURST);
            if (state == IDLE) begin
                regWrite_out <= regWrite_in;
                rd_out       <= rd_in;
                aluRes0_out  <= aluRes0_in;
                aluRes1_out  <= aluRes1_in;
                aluRes2_out  <= aluRes2_in;
                aluRes3_out  <= aluRes3_in;
                // A store issued with the pointer bump uses the pre-increment pointer
                if (storeGo) begin
                    mask     <= acceptMask;
                    base     <= ptr;
                    laneData <= {aluRes3_in, aluRes2_in, aluRes1_in, aluRes0_in};
                end
                if (updateCnt_in) ptr <= ptr + ADDR_W'(4);
            end else begin
                regWrite_out <= 1'b0;
                mask         <= maskNext;
            end
        end
    end

`ifdef VEC_STORE_CNT_EN
    // Completed-beat counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (reset)                    store_cnt <= '0;
        else if (mem_we && mem_ready) store_cnt <= store_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mem_vec_store_seq.sv
// Bench for mem_vec_store_seq: queue-based beat model compared every cycle, plus directed literal checks.
// Define VEC_STORE_CNT_EN to also check the store_cnt output.
module tb_mem_vec_store_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        regWrite_in, memWrite_in, updateCnt_in, select_in;
    logic [3:0]  rd_in, resCompare_in;
    logic [31:0] aluRes0_in, aluRes1_in, aluRes2_in, aluRes3_in;
    logic        mem_ready;
    logic        mem_we, stop, regWrite_out;
    logic [7:0]  mem_addr, ptr_out;
    logic [31:0] mem_wdata;
    logic [3:0]  rd_out;
    logic [31:0] aluRes0_out, aluRes1_out, aluRes2_out, aluRes3_out;
`ifdef VEC_STORE_CNT_EN
    logic [15:0] store_cnt;
`endif

    always #5 clk = ~clk;

    mem_vec_store_seq #(.ADDR_W(8), .BASE_ADDR(8'd0)) dut (
        .clk(clk), .reset(reset),
        .regWrite_in(regWrite_in), .memWrite_in(memWrite_in),
        .updateCnt_in(updateCnt_in), .select_in(select_in),
        .rd_in(rd_in), .resCompare_in(resCompare_in),
        .aluRes0_in(aluRes0_in), .aluRes1_in(aluRes1_in),
        .aluRes2_in(aluRes2_in), .aluRes3_in(aluRes3_in),
        .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .stop(stop), .regWrite_out(regWrite_out),
        .rd_out(rd_out), .aluRes0_out(aluRes0_out), .aluRes1_out(aluRes1_out),
        .aluRes2_out(aluRes2_out), .aluRes3_out(aluRes3_out),
`ifdef VEC_STORE_CNT_EN
        .store_cnt(store_cnt),
`endif
        .ptr_out(ptr_out)
    );

    typedef struct { logic [7:0] a; logic [31:0] d; } beat_t;

    int          tests = 0;
    int          fails = 0;
    bit          chkEn = 1'b0;
    int          stopCnt;
    int          logBase;
    beat_t       q[$];
    beat_t       wrLog[$];
    logic [7:0]  mPtr;
    logic        mRegWrite;
    logic [3:0]  mRd;
    logic [31:0] mAlu[4];
    logic [15:0] mCnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending beats held as a queue of (addr,data); busy whenever the queue is non-empty
    always @(posedge clk) begin
        if (mem_we && mem_ready) wrLog.push_back('{mem_addr, mem_wdata});
        if (reset) begin
            q.delete();
            mPtr = 8'd0; mRegWrite = 1'b0; mRd = 4'd0; mCnt = 16'd0;
            for (int i = 0; i < 4; i++) mAlu[i] = 32'd0;
        end else if (q.size() > 0) begin
            mRegWrite = 1'b0;
            if (mem_ready) begin
                void'(q.pop_front());
                mCnt = mCnt + 16'd1;
            end
        end else begin
            logic [31:0] in[4];
            logic [3:0]  m;
            in[0] = aluRes0_in; in[1] = aluRes1_in; in[2] = aluRes2_in; in[3] = aluRes3_in;
            mRegWrite = regWrite_in;
            mRd = rd_in;
            for (int i = 0; i < 4; i++) mAlu[i] = in[i];
            m = select_in ? resCompare_in : 4'b1111;
            if (memWrite_in)
                for (int i = 0; i < 4; i++)
                    if (m[i]) q.push_back('{8'(mPtr + 8'(i)), in[i]});
            if (updateCnt_in) mPtr = mPtr + 8'd4;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chkEn) begin
            chk("mem_we", 32'(mem_we), 32'((q.size() > 0) && !reset));
            if (q.size() > 0) begin
                chk("mem_addr", 32'(mem_addr), 32'(q[0].a));
                chk("mem_wdata", mem_wdata, q[0].d);
            end else begin
                chk("mem_addr_idle", 32'(mem_addr), 32'd0);
                chk("mem_wdata_idle", mem_wdata, 32'd0);
            end
            chk("stop", 32'(stop), 32'(q.size() > 0));
            chk("regWrite_out", 32'(regWrite_out), 32'(mRegWrite));
            chk("rd_out", 32'(rd_out), 32'(mRd));
            chk("aluRes0_out", aluRes0_out, mAlu[0]);
            chk("aluRes1_out", aluRes1_out, mAlu[1]);
            chk("aluRes2_out", aluRes2_out, mAlu[2]);
            chk("aluRes3_out", aluRes3_out, mAlu[3]);
            chk("ptr_out", 32'(ptr_out), 32'(mPtr));
`ifdef VEC_STORE_CNT_EN
            chk("store_cnt", 32'(store_cnt), 32'(mCnt));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (stop) stopCnt++;
        #1;
    endtask

    task automatic issue(input logic rw, input logic mw, input logic uc, input logic sel,
                         input logic [3:0] rd, input logic [3:0] rc,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3);
        regWrite_in = rw; memWrite_in = mw; updateCnt_in = uc; select_in = sel;
        rd_in = rd; resCompare_in = rc;
        aluRes0_in = a0; aluRes1_in = a1; aluRes2_in = a2; aluRes3_in = a3;
    endtask

    task automatic bubble();
        issue(0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, 0);
    endtask

    task automatic mark();
        stopCnt = 0;
        logBase = wrLog.size();
    endtask

    task automatic chkBeat(input string name, input int idx, input logic [7:0] a, input logic [31:0] d);
        if (wrLog.size() > logBase + idx) begin
            chk({name, "_addr"}, 32'(wrLog[logBase + idx].a), 32'(a));
            chk({name, "_data"}, wrLog[logBase + idx].d, d);
        end else begin
            chk({name, "_missing"}, 32'(wrLog.size() - logBase), 32'(idx + 1));
        end
    endtask

    initial begin
        stopCnt = 0; logBase = 0;
        bubble();
        mem_ready = 1'b1;
        reset = 1'b1;
        cyc(); cyc();
        chkEn = 1'b1;
        reset = 1'b0;
        chk("reset_stop", 32'(stop), 32'd0);
        chk("reset_ptr", 32'(ptr_out), 32'd0);
        chk("reset_rd_out", 32'(rd_out), 32'd0);

        // Unmasked store at ptr 0
        mark();
        issue(0, 1, 0, 0, 4'd0, 4'd0, 32'hAAAA_BBBB, 32'hCCCC_DDDD, 32'hEEEE_FFFF, 32'h1111_2222);
        cyc(); bubble();
        repeat (6) cyc();
        chk("full_beats", 32'(wrLog.size() - logBase), 32'd4);
        chkBeat("full0", 0, 8'd0, 32'hAAAA_BBBB);
        chkBeat("full1", 1, 8'd1, 32'hCCCC_DDDD);
        chkBeat("full2", 2, 8'd2, 32'hEEEE_FFFF);
        chkBeat("full3", 3, 8'd3, 32'h1111_2222);
        chk("full_stop_cycles", 32'(stopCnt), 32'd4);

        // Passthrough, then reset clears the forwarded values
        issue(1, 0, 0, 0, 4'b1010, 4'd0, 32'h1, 32'h2, 32'h3, 32'h4);
        cyc();
        chk("pass_regWrite", 32'(regWrite_out), 32'd1);
        chk("pass_rd", 32'(rd_out), 32'hA);
        chk("pass_alu3", aluRes3_out, 32'h4);
        reset = 1'b1;
        cyc();
        reset = 1'b0; bubble();
        chk("rst_regWrite", 32'(regWrite_out), 32'd0);
        chk("rst_rd", 32'(rd_out), 32'd0);
        chk("rst_alu0", aluRes0_out, 32'd0);

        // Empty mask: no write, no stall
        mark();
        issue(0, 1, 0, 1, 4'd0, 4'b0000, 32'h5, 32'h6, 32'h7, 32'h8);
        cyc(); bubble();
        repeat (3) cyc();
        chk("empty_beats", 32'(wrLog.size() - logBase), 32'd0);
        chk("empty_stop_cycles", 32'(stopCnt), 32'd0);

        // Pointer wrap
        repeat (63) begin
            issue(0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0, 0);
            cyc();
        end
        bubble();
        chk("ptr_252", 32'(ptr_out), 32'd252);
        issue(0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0, 0);
        cyc();
        chk("ptr_wrap", 32'(ptr_out), 32'd0);
        cyc();
        bubble();
        chk("ptr_4", 32'(ptr_out), 32'd4);

        // Store with simultaneous pointer bump uses the old pointer
        mark();
        issue(0, 1, 1, 0, 4'd0, 4'd0, 32'h40, 32'h41, 32'h42, 32'h43);
        cyc(); bubble();
        repeat (6) cyc();
        chkBeat("bump0", 0, 8'd4, 32'h40);
        chkBeat("bump3", 3, 8'd7, 32'h43);
        chk("bump_ptr", 32'(ptr_out), 32'd8);

        // Masked store 1010 at ptr 8
        mark();
        issue(0, 1, 0, 1, 4'd0, 4'b1010, 32'h90, 32'h91, 32'h92, 32'h93);
        cyc(); bubble();
        repeat (4) cyc();
        chk("mask_beats", 32'(wrLog.size() - logBase), 32'd2);
        chkBeat("mask0", 0, 8'd9, 32'h91);
        chkBeat("mask1", 1, 8'd11, 32'h93);
        chk("mask_stop_cycles", 32'(stopCnt), 32'd2);

        // Backpressure on the second beat
        mark();
        issue(0, 1, 0, 0, 4'd0, 4'd0, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
        cyc(); bubble();
        cyc();
        mem_ready = 1'b0;
        repeat (3) begin
            cyc();
            chk("bp_addr_hold", 32'(mem_addr), 32'd9);
            chk("bp_data_hold", mem_wdata, 32'hB1);
        end
        mem_ready = 1'b1;
        repeat (5) cyc();
        chk("bp_stop_cycles", 32'(stopCnt), 32'd7);
        chk("bp_beats", 32'(wrLog.size() - logBase), 32'd4);
        chkBeat("bp1", 1, 8'd9, 32'hB1);
        chkBeat("bp3", 3, 8'd11, 32'hB3);

        // Reset after lane 1 of a full store
        mark();
        issue(0, 1, 0, 0, 4'd0, 4'd0, 32'hC0, 32'hC1, 32'hC2, 32'hC3);
        cyc(); bubble();
        cyc(); cyc();
        reset = 1'b1; mem_ready = 1'b0;
        cyc();
        reset = 1'b0; mem_ready = 1'b1;
        repeat (3) cyc();
        chk("abort_beats", 32'(wrLog.size() - logBase), 32'd2);
        chk("abort_stop", 32'(stop), 32'd0);
        chk("abort_ptr", 32'(ptr_out), 32'd0);
`ifdef VEC_STORE_CNT_EN
        chk("abort_cnt", 32'(store_cnt), 32'd0);
`endif

        // Randomised traffic
        repeat (3000) begin
            issue(1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  1'($urandom), 4'($urandom), 4'($urandom),
                  $urandom, $urandom, $urandom, $urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset = 1'b0;
        bubble();
        mem_ready = 1'b1;
        repeat (8) cyc();
        chk("final_idle", 32'(stop), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_vec_store_seq.md
Name: mem_vec_store_seq

Overview:
- Memory-stage sequencer directly downstream of the EXE/MEM pipeline register.
- Consumes the register's control bits (regWrite, memWrite, updateCnt, select), rd, resCompare and the four 32-bit lane results.
- Serialises a 4-lane vector store onto a single 32-bit data-memory port, one lane per beat, with a pointer-based store address.
- Stalls the upstream pipeline (stop) while a burst is in flight and forwards register-write information to the MEM/WB register with 1-cycle latency.

Parameters:
- ADDR_W, 8, word-address width of the data-memory port; the pointer wraps modulo 2^ADDR_W.
- BASE_ADDR, 0, pointer value after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- regWrite_in  in  1  register-write request from EXE/MEM.
- memWrite_in  in  1  vector-store request.
- updateCnt_in  in  1  advance store pointer by 4 words.
- select_in  in  1  1 = masked store using resCompare_in; 0 = all 4 lanes.
- rd_in  in  4  destination register.
- resCompare_in  in  4  per-lane compare mask; bit i = lane i.
- aluRes0_in..aluRes3_in  in  32 each  lane data.
- mem_ready  in  1  memory accepts the current beat this cycle.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- stop  out  1  stall request to EXE/MEM and earlier stages.
- regWrite_out  out  1  to MEM/WB.
- rd_out  out  4  to MEM/WB.
- aluRes0_out..aluRes3_out  out  32 each  to MEM/WB.
- ptr_out  out  ADDR_W  current store pointer (debug/observability).

Behaviour:
- Reset:
  - state = IDLE, ptr = BASE_ADDR.
  - stop, mem_we, regWrite_out = 0.
  - mem_addr, mem_wdata, rd_out and aluRes*_out = 0.
- States: IDLE, BURST.
- IDLE, every cycle, the inputs are accepted as one instruction (an all-zero input is a bubble):
  - regWrite_out, rd_out and aluRes*_out are registered from the inputs (1-cycle latency).
  - mask = select_in ? resCompare_in : 4'b1111.
  - If memWrite_in=1 and mask!=0: capture mask, lane data and base address = ptr. Go to BURST; stop=1 from the next cycle.
  - If memWrite_in=1 and mask=0: no write, no stall, stay in IDLE.
  - If updateCnt_in=1: ptr <= ptr+4 (wraps). When it coincides with a store, the store uses the pre-increment ptr.
- stop is registered:
  - The EXE/MEM register loads one new instruction during the acceptance cycle, then holds it while stop=1.
  - That held instruction is ignored until return to IDLE and is accepted on the first IDLE cycle.
- BURST:
  - Lane index = lowest set bit remaining in the captured mask.
  - Drive mem_we=1, mem_addr = base+lane (mod 2^ADDR_W), mem_wdata = captured lane data, combinationally from state.
  - The beat completes on a cycle with mem_ready=1; that lane's mask bit is then cleared.
  - mem_ready=0 holds all mem_* outputs stable; there is no timeout.
  - Unmasked lanes are skipped with zero cycles; the number of beats = popcount(mask).
  - After the final beat completes, the next state is IDLE and stop=0 in that same next cycle.
  - regWrite_out=0 for every cycle in BURST (bubble to WB); rd_out and aluRes*_out hold.
- Example timing: full mask with mem_ready tied to 1 gives 4 beats; stop is high for exactly 4 cycles.
- Reset asserted mid-burst:
  - The burst is abandoned immediately and remaining lanes are not written.
  - All reset values apply on the next edge.

Optional Feature:
- Macro VEC_STORE_CNT_EN.
- When defined: add output store_cnt [15:0].
  - Reset to 0.
  - Increments by 1 per completed beat (mem_we && mem_ready).
  - Wraps 16'hFFFF -> 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then an unmasked store (memWrite_in=1, select_in=0, aluRes0..3 = AAAA_BBBB, CCCC_DDDD, EEEE_FFFF, 1111_2222), mem_ready=1 -> writes to addr 0,1,2,3 with those data on consecutive cycles; stop high 4 cycles; regWrite_out=0 during burst.
- Masked store: select_in=1, resCompare_in=4'b1010, ptr=8 -> exactly 2 beats: addr 9 = aluRes1, addr 11 = aluRes3; stop high 2 cycles; mask 4'b0000 -> no mem_we, stop stays 0.
- Backpressure: mem_ready=0 for 3 cycles on beat 2 of a full store -> mem_addr/mem_wdata held stable; stop high 7 cycles total; no duplicate or lost beats.
- Pointer: updateCnt_in pulses with ADDR_W=8 starting at ptr=252 -> ptr_out=0 after wrap; updateCnt_in+memWrite_in together at ptr=4 -> burst writes 4..7 and ptr_out becomes 8.
- Passthrough: regWrite_in=1, rd_in=4'b1010, memWrite_in=0 -> next cycle regWrite_out=1, rd_out=4'b1010, aluRes*_out equal to inputs; a reset pulse then clears all outputs to 0.
- Reset mid-burst after lane 1 of a full store -> lanes 2,3 not written; stop=0, ptr=BASE_ADDR; with VEC_STORE_CNT_EN, store_cnt goes 2 -> 0.
